alu_issue_ctrl: RTL and testbench

- Issue-side controller for the team's 2-bit-opcode ALU (ADD/SUB/SHIFTL/SHIFTR).
- Accepts register-addressed instructions over a valid/ready handshake and reads operands from an internal register file.
- Drives opcode/A/B to an external combinational ALU instance, captures its result, writes it back and reports completion.
- Sits between an instruction source (testbench or fetch unit) and the ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU issue controller slice.
// Opcode encoding matches the external 2-bit ALU.
package alu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 3;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        SHL = 2'b10,
        SHR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue controller: one write port and three
// combinational read ports (two operands plus a debug port).
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] ra3,
    output logic [DATA_W-1:0] rd3
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is reset entry by entry because reset must return every
    // register to zero; this keeps it a flop array rather than an inferred RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];
    assign rd3 = mem[ra3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue-side controller: accepts register-addressed instructions, feeds an
// external combinational ALU, writes the result back and pulses completion.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    output logic [1:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done_valid,
    output logic [REG_AW-1:0] done_rd,
    output logic [DATA_W-1:0] done_data,
    input  logic              load_en,
    input  logic [REG_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    ctrl_state_t       state, state_next;
    logic [REG_AW-1:0] rd_q;
    logic              accept;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    alu_regfile #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_regfile (
        .clk  (clk),
        .rst  (rst),
        .we   (rf_we),
        .waddr(rf_waddr),
        .wdata(rf_wdata),
        .ra1  (in_rs1),
        .rd1  (rs1_data),
        .ra2  (in_rs2),
        .rd2  (rs2_data),
        .ra3  (rd_addr),
        .rd3  (rd_data)
    );

    // Preload shares the write port with writeback; a load in IDLE blocks accept.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = load_addr;
        rf_wdata   = load_data;
        unique case (state)
            IDLE: begin
                in_ready = !load_en;
                rf_we    = load_en;
                if (in_valid && !load_en) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                rf_we      = 1'b1;
                rf_waddr   = rd_q;
                rf_wdata   = alu_result;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, which is why rd == rs1/rs2 reads the old register contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rd_q       <= '0;
            done_valid <= 1'b0;
            done_rd    <= '0;
            done_data  <= '0;
        end else begin
            done_valid <= (state == ISSUE);
            if (accept) begin
                alu_opcode <= in_op;
                alu_a      <= rs1_data;
                alu_b      <= rs2_data;
                rd_q       <= in_rd;
            end
            if (state == ISSUE) begin
                done_rd   <= rd_q;
                done_data <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU beside it and a
// scoreboard of expected completions checked whenever done_valid fires.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;
    logic [1:0]    alu_opcode;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          done_valid;
    logic [AW-1:0] done_rd;
    logic [DW-1:0] done_data;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb_q[$];
    int            done_cycs[$];
    logic [DW-1:0] ref_rf [8];
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .alu_opcode(alu_opcode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result),
        .done_valid(done_valid),
        .done_rd   (done_rd),
        .done_data (done_data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a << b;
            default: return a >> b;
        endcase
    endfunction

    // External ALU model driven by the controller's registered outputs.
    always_comb alu_result = ref_alu(alu_opcode, alu_a, alu_b);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (done_valid !== 1'b0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_done", {31'd0, done_valid}, '0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                done_cycs.push_back(cyc);
                check("sb_rd", {29'd0, done_rd}, {29'd0, e.rd});
                check("sb_data", done_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_en = 1'b0;
        ref_rf[addr] = data;
    endtask

    task automatic expect_push(input logic [1:0] op, input logic [AW-1:0] rd,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        logic [DW-1:0] r;
        r = ref_alu(op, ref_rf[rs1], ref_rf[rs2]);
        sb_q.push_back('{rd, r});
        ref_rf[rd] = r;
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [DW-1:0] exp_const);
        logic [DW-1:0] a, b;
        int n;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        if (n == 10) check({tag, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        expect_push(op, rd, rs1, rs2);
        tick();
        in_valid = 1'b0;
        check({tag, "_alu_op"}, {30'd0, alu_opcode}, {30'd0, op});
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        tick();
        check({tag, "_done_valid"}, {31'd0, done_valid}, 32'd1);
        check({tag, "_done_data"}, done_data, exp_const);
        rd_addr = rd;
        #1;
        check({tag, "_rd_data"}, rd_data, exp_const);
        tick();
        check({tag, "_done_drop"}, {31'd0, done_valid}, 32'd0);
        check({tag, "_done_hold"}, done_data, exp_const);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0; rd_addr = '0;
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        #12;
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_op", {30'd0, alu_opcode}, '0);
        check("rst_done_valid", {31'd0, done_valid}, '0);
        check("rst_done_data", done_data, '0);
        rst = 1'b0;
        tick();
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        issue("add", 2'b00, 3'd3, 3'd1, 3'd2, 32'd8);
        issue("sub_wrap", 2'b01, 3'd6, 3'd2, 3'd1, 32'hFFFF_FFFE);
        load(3'd4, 32'd1);
        load(3'd5, 32'd31);
        issue("shl31", 2'b10, 3'd7, 3'd4, 3'd5, 32'h8000_0000);
        load(3'd5, 32'd32);
        issue("shl32", 2'b10, 3'd7, 3'd4, 3'd5, 32'd0);
        load(3'd4, 32'h8000_0000);
        load(3'd5, 32'd31);
        issue("shr31", 2'b11, 3'd6, 3'd4, 3'd5, 32'd1);
        load(3'd1, 32'd7);
        issue("self1", 2'b00, 3'd1, 3'd1, 3'd1, 32'd14);
        issue("self2", 2'b00, 3'd1, 3'd1, 3'd1, 32'd28);

        // Back-to-back with in_valid held high: r3 = 28 + 3, then r0 = r3 - r2.
        in_op = 2'b00; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2; in_valid = 1'b1;
        #1;
        check("b2b_ready0", {31'd0, in_ready}, 32'd1);
        expect_push(2'b00, 3'd3, 3'd1, 3'd2);
        tick();
        in_op = 2'b01; in_rd = 3'd0; in_rs1 = 3'd3; in_rs2 = 3'd2;
        #1;
        expect_push(2'b01, 3'd0, 3'd3, 3'd2);
        check("b2b_busy_issue", {31'd0, in_ready}, 32'd0);
        tick();
        check("b2b_busy_done", {31'd0, in_ready}, 32'd0);
        check("b2b_first_data", done_data, 32'd31);
        tick();
        check("b2b_ready_again", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_second_a", alu_a, 32'd31);
        tick();
        check("b2b_second_data", done_data, 32'd28);
        tick();
        check("b2b_no_third", {31'd0, done_valid}, 32'd0);
        if (done_cycs.size() >= 2)
            check("b2b_gap", done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2], 32'd3);
        else
            check("b2b_pulses", done_cycs.size(), 32'd2);

        // Load priority: load and instruction together, load lands first.
        load_en = 1'b1; load_addr = 3'd1; load_data = 32'd100;
        in_op = 2'b00; in_rd = 3'd2; in_rs1 = 3'd1; in_rs2 = 3'd1; in_valid = 1'b1;
        #1;
        check("ldpri_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        load_en = 1'b0;
        ref_rf[1] = 32'd100;
        rd_addr = 3'd1;
        #1;
        check("ldpri_loaded", rd_data, 32'd100);
        check("ldpri_ready_high", {31'd0, in_ready}, 32'd1);
        expect_push(2'b00, 3'd2, 3'd1, 3'd1);
        tick();
        in_valid = 1'b0;
        check("ldpri_alu_a", alu_a, 32'd100);
        tick();
        check("ldpri_data", done_data, 32'd200);
        tick();

        // Reset during ISSUE aborts the instruction.
        in_op = 2'b00; in_rd = 3'd5; in_rs1 = 3'd1; in_rs2 = 3'd2; in_valid = 1'b1;
        #1;
        expect_push(2'b00, 3'd5, 3'd1, 3'd2);
        tick();
        in_valid = 1'b0;
        check("abort_pre_a", alu_a, 32'd100);
        rst = 1'b1;
        #1;
        void'(sb_q.pop_back());
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        check("abort_alu_a", alu_a, '0);
        check("abort_alu_b", alu_b, '0);
        check("abort_done_data", done_data, '0);
        check("abort_done_rd", {29'd0, done_rd}, '0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("abort_rf%0d", i), rd_data, '0);
        end
        tick();
        tick();
        check("abort_no_done", {31'd0, done_valid}, '0);
        rst = 1'b0;
        tick();
        load(3'd1, 32'd2);
        load(3'd2, 32'd9);
        issue("post_rst_add", 2'b00, 3'd3, 3'd1, 3'd2, 32'd11);

        tick();
        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
